// File: rtl/pipelined_carry_adder_pkg.sv
// Shared types and helpers for the chunked, pipelined add/subtract unit.
package pipelined_carry_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK_WIDTH slice of the pipelined adder: chunk sum, registered carry,
// valid bit and signed-overflow flag, all frozen while en is low.
module adder_chunk_stage
    import pipelined_carry_adder_pkg::*;
#(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   valid_in,
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   carry_in,
    output logic                   valid_q,
    output logic [CHUNK_WIDTH-1:0] sum_q,
    output logic                   carry_q,
    output logic                   ovf_q
);

    localparam int SUM_W = CHUNK_WIDTH + 1;

    logic [SUM_W-1:0] full;
    logic             carry_into_msb;

    always_comb begin
        full           = {1'b0, a} + {1'b0, b} + SUM_W'(carry_in);
        // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
        carry_into_msb = a[CHUNK_WIDTH-1] ^ b[CHUNK_WIDTH-1] ^ full[CHUNK_WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_in;
            sum_q   <= full[CHUNK_WIDTH-1:0];
            carry_q <= full[CHUNK_WIDTH];
            ovf_q   <= carry_into_msb ^ full[CHUNK_WIDTH];
        end
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract, one CHUNK_WIDTH slice per stage, valid/ready on both sides.
// Optional signed-overflow output is enabled by PIPELINED_CARRY_ADDER_OVERFLOW_EN.
module pipelined_carry_adder
    import pipelined_carry_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carryIn,
    input  op_t              op,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             carryOut
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK_WIDTH);

    if ((WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
        $error("pipelined_carry_adder: WIDTH must be a multiple of CHUNK_WIDTH");
    end

    logic                                    advance;
    logic [WIDTH-1:0]                        b_cap;
    // operand bits not yet consumed, shifted so chunk 0 feeds stage k
    logic [NUM_CHUNKS-1:0][WIDTH-1:0]        a_src;
    logic [NUM_CHUNKS-1:0][WIDTH-1:0]        b_src;
    // result chunks 0..k, aligned to the top of the word
    logic [NUM_CHUNKS-1:0][WIDTH-1:0]        part;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0]  s_q;
    logic [NUM_CHUNKS-1:0]                   v_q;
    logic [NUM_CHUNKS-1:0]                   c_q;
    logic [NUM_CHUNKS-1:0]                   o_q;

    assign inReady = !(outValid && !outReady);
    assign advance = inReady;
    assign b_cap   = (op == OP_SUB) ? ~in2 : in2;

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_stage
        logic [CHUNK_WIDTH-1:0] a_chunk;
        logic [CHUNK_WIDTH-1:0] b_chunk;
        logic                   c_in;
        logic                   v_in;

        if (k == 0) begin : g_head
            assign a_src[0] = in1;
            assign b_src[0] = b_cap;
            assign c_in     = carryIn;
            assign v_in     = inValid;
            assign part[0]  = WIDTH'(s_q[0]) << (WIDTH - CHUNK_WIDTH);
        end else begin : g_body
            logic [WIDTH-1:0] low_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    low_q <= '0;
                end else if (advance) begin
                    low_q <= part[k-1];
                end
            end

            assign c_in    = c_q[k-1];
            assign v_in    = v_q[k-1];
            assign part[k] = (low_q >> CHUNK_WIDTH) |
                             (WIDTH'(s_q[k]) << (WIDTH - CHUNK_WIDTH));
        end

        assign a_chunk = CHUNK_WIDTH'(a_src[k]);
        assign b_chunk = CHUNK_WIDTH'(b_src[k]);

        if (k < NUM_CHUNKS - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[k] >> CHUNK_WIDTH;
                    b_q <= b_src[k] >> CHUNK_WIDTH;
                end
            end

            assign a_src[k+1] = a_q;
            assign b_src[k+1] = b_q;
        end

        adder_chunk_stage #(
            .CHUNK_WIDTH (CHUNK_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .valid_in (v_in),
            .a        (a_chunk),
            .b        (b_chunk),
            .carry_in (c_in),
            .valid_q  (v_q[k]),
            .sum_q    (s_q[k]),
            .carry_q  (c_q[k]),
            .ovf_q    (o_q[k])
        );
    end

    assign outValid = v_q[NUM_CHUNKS-1];
    assign out      = part[NUM_CHUNKS-1];
    assign carryOut = c_q[NUM_CHUNKS-1];

    // only the last stage's overflow flag and the low operand chunk of the last stage matter
    logic unused_bits;
    assign unused_bits = ^{o_q, a_src[NUM_CHUNKS-1], b_src[NUM_CHUNKS-1]};

`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
    assign overflow = o_q[NUM_CHUNKS-1];
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder at WIDTH=16, CHUNK_WIDTH=4.
// Overflow checks are active when PIPELINED_CARRY_ADDER_OVERFLOW_EN is defined.
module tb_pipelined_carry_adder;
    import pipelined_carry_adder_pkg::*;

    localparam int W   = 16;
    localparam int CW  = 4;
    localparam int LAT = W / CW;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         inValid  = 1'b0;
    logic         inReady;
    logic [W-1:0] in1      = '0;
    logic [W-1:0] in2      = '0;
    logic         carryIn  = 1'b0;
    op_t          op       = OP_ADD;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [W-1:0] out;
    logic         carryOut;
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    pipelined_carry_adder #(
        .WIDTH       (W),
        .CHUNK_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .in1      (in1),
        .in2      (in2),
        .carryIn  (carryIn),
        .op       (op),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .carryOut (carryOut)
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic         c;
        logic         v;
        int           t;
    } exp_t;

    exp_t         q[$];
    bit           acc_hist[int];
    int           checks = 0;
    int           passes = 0;
    int           cyc    = 0;
    int           n_out  = 0;
    int           n_acc  = 0;
    bit           chk_lat, chk_pat, chk_stall;
    bit           held_ok;
    logic [W-1:0] held_out;
    logic         held_c;
    logic [W-1:0] last_out;
    logic         last_c;
    logic         last_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: plain wide arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input op_t o);
        exp_t         r;
        logic [W-1:0] bv;
        logic [W:0]   s;
        bv  = (o == OP_SUB) ? ~b : b;
        s   = {1'b0, a} + {1'b0, bv} + (W+1)'(cin);
        r.o = s[W-1:0];
        r.c = s[W];
        r.v = (a[W-1] == bv[W-1]) && (s[W-1] != a[W-1]);
        r.t = 0;
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (outValid === 1'b1 && outReady) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_outValid", outValid, 0);
            end else begin
                e = q.pop_front();
                check("out", out, e.o);
                check("carryOut", carryOut, e.c);
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
                check("overflow", overflow, e.v);
                last_v = overflow;
`endif
                if (chk_lat) check("latency", cyc - e.t, LAT);
                last_out = out;
                last_c   = carryOut;
            end
        end
        if (chk_pat && cyc >= LAT)
            check("valid_pattern", outValid, acc_hist.exists(cyc - LAT) ? 1 : 0);
        if (chk_stall && outValid === 1'b1 && !outReady) begin
            check("inReady_stall", inReady, 0);
            if (held_ok) begin
                check("stall_out_stable", out, held_out);
                check("stall_carry_stable", carryOut, held_c);
            end else begin
                held_out = out;
                held_c   = carryOut;
                held_ok  = 1'b1;
            end
        end else begin
            held_ok = 1'b0;
        end
        if (inValid && inReady === 1'b1) begin
            e   = model(in1, in2, carryIn, op);
            e.t = cyc;
            q.push_back(e);
            acc_hist[cyc] = 1'b1;
            n_acc++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input op_t o);
        inValid = 1'b1;
        in1     = a;
        in2     = b;
        carryIn = c;
        op      = o;
        tick();
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_inputs();
        in1     = W'($urandom);
        in2     = W'($urandom);
        carryIn = 1'($urandom);
        op      = op_t'(1'($urandom));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // reset state
        #12;
        check("rst_outValid", outValid, 0);
        check("rst_out", out, 0);
        check("rst_carryOut", carryOut, 0);
        check("rst_inReady", inReady, 1);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        chk_lat  = 1'b1;

        // full carry ripple
        send(16'hFFFF, 16'h0001, 1'b0, OP_ADD);
        idle(LAT + 1);
        check("ripple_out", last_out, 16'h0000);
        check("ripple_carry", last_c, 1);
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
        check("ripple_ovf", last_v, 0);
`endif

        // subtracts
        send(16'h0005, 16'h0007, 1'b1, OP_SUB);
        idle(LAT + 1);
        check("sub_out", last_out, 16'hFFFE);
        check("sub_carry", last_c, 0);
        send(16'h8000, 16'h0001, 1'b1, OP_SUB);
        idle(LAT + 1);
        check("sub_ovf_out", last_out, 16'h7FFF);
        check("sub_ovf_carry", last_c, 1);
`ifdef PIPELINED_CARRY_ADDER_OVERFLOW_EN
        check("sub_ovf_flag", last_v, 1);
`endif

        // throughput: 20 back-to-back random operations
        base = n_out;
        for (int i = 0; i < 20; i++) begin
            check("inReady_tput", inReady, 1);
            inValid = 1'b1;
            rand_inputs();
            tick();
        end
        idle(LAT + 1);
        check("tput_count", n_out - base, 20);
        check("tput_drained", q.size(), 0);

        // backpressure with the pipe full
        chk_lat   = 1'b0;
        chk_stall = 1'b1;
        outReady  = 1'b0;
        base      = n_acc;
        inValid   = 1'b1;
        rand_inputs();
        for (int i = 0; i < 10; i++) begin
            if (inReady === 1'b1) rand_inputs();
            tick();
        end
        check("bp_stalled_valid", outValid, 1);
        check("bp_stalled_ready", inReady, 0);
        inValid  = 1'b0;
        outReady = 1'b1;
        base     = n_out;
        idle(LAT + 4);
        check("bp_count", n_out - base, LAT);
        check("bp_drained", q.size(), 0);
        chk_stall = 1'b0;

        // bubbles
        chk_lat = 1'b1;
        chk_pat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inValid = (i % 2 == 0);
            rand_inputs();
            tick();
        end
        idle(LAT + 2);
        chk_pat = 1'b0;
        check("bubble_drained", q.size(), 0);

        // asynchronous reset with three operations in flight
        outReady = 1'b0;
        chk_lat  = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, OP_ADD);
        send(16'hA5A5, 16'h0F0F, 1'b1, OP_ADD);
        send(16'h00FF, 16'h0100, 1'b1, OP_SUB);
        idle(2);
        check("prerst_outValid", outValid, 1);
        check("prerst_out", out, 16'h2345);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outValid", outValid, 0);
        check("midrst_out", out, 0);
        check("midrst_carryOut", carryOut, 0);
        check("midrst_inReady", inReady, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            idle(1);
            check("postrst_idle_valid", outValid, 0);
        end
        chk_lat = 1'b1;
        base    = n_out;
        send(16'h7FFF, 16'h0001, 1'b0, OP_ADD);
        idle(LAT + 1);
        check("postrst_count", n_out - base, 1);
        check("postrst_out", last_out, 16'h8000);
        check("postrst_carry", last_c, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
